// File: rtl/cache_pkg.sv
// Shared state encoding and geometry constants for the data-cache block fill.
package cache_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_IDX_W  = 3;
    localparam int unsigned BLOCK_OFF_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFill = 2'b01
    } fill_state_e;

    // Word index within the block, wrapping so a fill never carries into the tag.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [WORD_IDX_W-1:0] start,
                                                         input logic [WORD_IDX_W-1:0] offset);
        return start + offset;
    endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Per-fill word counter: clears at the start of a fill, counts up to LIMIT and holds there.
module fill_word_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count,
    output logic       done
);

    logic [3:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en && !done) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign count = count_q;
    assign done  = (count_q == 4'(LIMIT));

endmodule

// File: rtl/data_cache_fill_fsm.sv
// Data-cache miss fill: requests one block word per cycle and writes returned words back.
// Define CACHE_FILL_CWF_EN to fetch the critical (missing) word first.
module data_cache_fill_fsm #(
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_word_addr,
    output logic              write_tag_array
);

    import cache_pkg::*;

    localparam int unsigned TAG_W = ADDR_W - BLOCK_OFF_W;

    fill_state_e           state_q;
    logic [TAG_W-1:0]      base_q;
    logic [WORD_IDX_W-1:0] start_q;
    logic [WORD_IDX_W-1:0] start_d;
    logic [WORD_IDX_W-1:0] req_idx;
    logic [WORD_IDX_W-1:0] rsp_idx;
    logic [3:0]            req_cnt;
    logic [3:0]            rsp_cnt;
    logic                  req_done;
    logic                  rsp_done;
    logic                  accept;
    logic                  req_en;
    logic                  rsp_en;
    logic                  last_rsp;
    logic                  unused_addr_lsbs;

`ifdef CACHE_FILL_CWF_EN
    assign start_d = miss_address[BLOCK_OFF_W-1:1];
`else
    assign start_d = '0;
`endif

    assign unused_addr_lsbs = ^miss_address[BLOCK_OFF_W-1:0];

    assign accept   = (state_q == StIdle) && miss_detected;
    assign req_en   = (state_q == StFill) && !req_done;
    assign rsp_en   = (state_q == StFill) && memory_data_valid && !rsp_done;
    assign last_rsp = rsp_en && (rsp_cnt == 4'(BLOCK_WORDS - 1));

    assign req_idx = word_index(start_q, req_cnt[WORD_IDX_W-1:0]);
    assign rsp_idx = word_index(start_q, rsp_cnt[WORD_IDX_W-1:0]);

    fill_word_counter #(
        .LIMIT (BLOCK_WORDS)
    ) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (req_en),
        .count (req_cnt),
        .done  (req_done)
    );

    fill_word_counter #(
        .LIMIT (BLOCK_WORDS)
    ) u_rsp_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (rsp_en),
        .count (rsp_cnt),
        .done  (rsp_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            start_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (miss_detected) begin
                        base_q  <= miss_address[ADDR_W-1:BLOCK_OFF_W];
                        start_q <= start_d;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (last_rsp) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // A response must always belong to a request already issued (or issued now).
            if ((state_q == StFill) && memory_data_valid) begin
                assert (rsp_cnt < req_cnt + {3'b000, req_en});
            end
        end
    end

    // Stall and strobes respond in the same cycle; everything is forced low while in reset.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        memory_address   = '0;
        fill_word_addr   = '0;
        if (!rst) begin
            fsm_busy         = (state_q == StFill) || miss_detected;
            mem_req          = req_en;
            write_data_array = rsp_en;
            write_tag_array  = last_rsp;
            memory_address   = {base_q, req_idx, 1'b0};
            fill_word_addr   = {base_q, rsp_idx, 1'b0};
        end
    end

endmodule

// File: tb/tb_data_cache_fill_fsm.sv
// Randomized self-checking bench for data_cache_fill_fsm against a block-level fill model.
module tb_data_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_word_addr;
    logic        write_tag_array;

    data_cache_fill_fsm #(
        .BLOCK_WORDS (8),
        .ADDR_W      (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_addr    (fill_word_addr),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Address of the k-th word fetched for a miss, straight from the fill-order rule.
    function automatic logic [15:0] word_addr(input logic [15:0] a, input int k);
        int s;
`ifdef CACHE_FILL_CWF_EN
        s = int'(a[3:1]);
`else
        s = 0;
`endif
        return (a & 16'hFFF0) | 16'(((s + k) % 8) * 2);
    endfunction

    // Model: an active fill is a list of 8 addresses plus counts of requests and responses.
    bit          m_active = 1'b0;
    bit          m_fresh  = 1'b1;
    int          m_issued = 0;
    int          m_rsps   = 0;
    logic [15:0] m_list [8];

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_fresh  <= 1'b1;
            m_issued <= 0;
            m_rsps   <= 0;
        end else if (!m_active) begin
            if (miss_detected) begin
                m_active <= 1'b1;
                m_fresh  <= 1'b0;
                m_issued <= 0;
                m_rsps   <= 0;
                for (int k = 0; k < 8; k++) m_list[k] <= word_addr(miss_address, k);
            end
        end else begin
            if (m_issued < 8) m_issued <= m_issued + 1;
            if (memory_data_valid) begin
                m_rsps <= m_rsps + 1;
                if (m_rsps == 7) m_active <= 1'b0;
            end
        end
    end

    // Observation log for the directed literal checks.
    logic [15:0] obs_req[$];
    logic [15:0] obs_wr[$];
    int          obs_tag  = 0;
    int          obs_busy = 0;

    task automatic clear_obs();
        obs_req.delete();
        obs_wr.delete();
        obs_tag  = 0;
        obs_busy = 0;
    endtask

    logic e_busy, e_req, e_wda, e_tag;

    always @(negedge clk) begin
        #2;
        e_busy = !rst && (m_active || miss_detected);
        e_req  = !rst && m_active && (m_issued < 8);
        e_wda  = !rst && m_active && memory_data_valid;
        e_tag  = e_wda && (m_rsps == 7);
        check("fsm_busy", 16'(fsm_busy), 16'(e_busy));
        check("mem_req", 16'(mem_req), 16'(e_req));
        check("write_data_array", 16'(write_data_array), 16'(e_wda));
        check("write_tag_array", 16'(write_tag_array), 16'(e_tag));
        if (rst || m_fresh) begin
            check("memory_address_reset", memory_address, 16'h0);
            check("fill_word_addr_reset", fill_word_addr, 16'h0);
        end else begin
            if (e_req) check("memory_address", memory_address, m_list[m_issued]);
            if (e_wda) check("fill_word_addr", fill_word_addr, m_list[m_rsps]);
        end
        if (mem_req === 1'b1) obs_req.push_back(memory_address);
        if (write_data_array === 1'b1) obs_wr.push_back(fill_word_addr);
        if (write_tag_array === 1'b1) obs_tag++;
        if (fsm_busy === 1'b1) obs_busy++;
    end

    // Memory: answers each sampled request in order after a latency, with a minimum gap.
    int cyc = 0;
    int due[$];
    int lat_min = 4;
    int lat_max = 4;
    int gap = 1;
    int last_rsp = -100;
    bit stray_en = 1'b0;

    initial begin
        int d;
        forever begin
            @(negedge clk);
            cyc++;
            if (due.size() > 0 && due[0] <= cyc && (cyc - last_rsp) >= gap) begin
                memory_data_valid = 1'b1;
                void'(due.pop_front());
                last_rsp = cyc;
            end else begin
                memory_data_valid = stray_en && (due.size() == 0) && ($urandom_range(0, 1) == 1);
            end
            #4;
            if (rst) begin
                due.delete();
            end else if (mem_req === 1'b1) begin
                d = cyc + int'($urandom_range(lat_min, lat_max));
                if (due.size() > 0 && d < due[$]) d = due[$];
                due.push_back(d);
            end
        end
    end

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #3;
            if (fsm_busy === 1'b0 && !m_active) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout at %0t: busy=%b still set after 200 cycles", name, $time,
                     fsm_busy);
        end
    endtask

    task automatic miss_pulse(input logic [15:0] a);
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = a;
        @(negedge clk);
        miss_detected = 1'b0;
    endtask

    task automatic check_seq(input string name, input logic [15:0] q[$],
                             input logic [15:0] exp [8]);
        check({name, "_count"}, 16'(q.size()), 16'd8);
        for (int i = 0; i < 8 && i < q.size(); i++) check(name, q[i], exp[i]);
    endtask

    logic [15:0] exp_a [8];

    initial begin
        #400000;
        $display("FAIL watchdog at %0t: bench did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with stray responses, then idle strays: nothing may be written.
        stray_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_obs();
        repeat (5) @(negedge clk);
        #3;
        check("stray_idle_writes", 16'(obs_wr.size()), 16'd0);
        @(negedge clk);
        stray_en = 1'b0;

        // Miss at 0x1234, memory latency 4.
        lat_min = 4; lat_max = 4; gap = 1;
        clear_obs();
        miss_pulse(16'h1234);
        wait_idle("fill_1234");
`ifdef CACHE_FILL_CWF_EN
        exp_a = '{16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232};
`else
        exp_a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif
        check_seq("req_order_1234", obs_req, exp_a);
        check_seq("wr_order_1234", obs_wr, exp_a);
        check("tag_count_1234", 16'(obs_tag), 16'd1);
        // Accept cycle plus 12 busy cycles.
        check("busy_cycles_1234", 16'(obs_busy), 16'd13);

        // Top-of-block miss: index wraps without carrying into the tag.
        clear_obs();
        miss_pulse(16'hFFFE);
        wait_idle("fill_fffe");
        check("req_count_fffe", 16'(obs_req.size()), 16'd8);
        if (obs_req.size() >= 2) begin
`ifdef CACHE_FILL_CWF_EN
            check("req0_fffe", obs_req[0], 16'hFFFE);
            check("req1_fffe", obs_req[1], 16'hFFF0);
`else
            check("req0_fffe", obs_req[0], 16'hFFF0);
            check("req1_fffe", obs_req[1], 16'hFFF2);
`endif
        end

        // Miss address changes mid-fill; the held miss starts a fresh fill afterwards.
        lat_min = 2; lat_max = 2;
        clear_obs();
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        repeat (3) @(negedge clk);
        miss_address = 16'h4000;
        for (int i = 0; i < 100 && obs_req.size() < 9; i++) begin
            @(negedge clk);
            #3;
        end
        check("second_fill_started", 16'(obs_req.size() >= 9), 16'd1);
        @(negedge clk);
        miss_detected = 1'b0;
        wait_idle("fill_4000");
        if (obs_req.size() >= 9) begin
            for (int i = 0; i < 8; i++) check("first_block_kept", obs_req[i] & 16'hFFF0, 16'h1230);
            check("second_fill_addr", obs_req[8], 16'h4000);
        end
        check("tag_count_two_fills", 16'(obs_tag), 16'd2);

        // Responses every third cycle.
        lat_min = 1; lat_max = 1; gap = 3;
        clear_obs();
        miss_pulse(16'h2A5C);
        wait_idle("fill_gap3");
        check("req_count_gap3", 16'(obs_req.size()), 16'd8);
        check("wr_count_gap3", 16'(obs_wr.size()), 16'd8);
        check("tag_count_gap3", 16'(obs_tag), 16'd1);

        // Reset after three responses aborts the fill; later strays write nothing.
        lat_min = 2; lat_max = 2; gap = 1;
        clear_obs();
        miss_pulse(16'h7776);
        for (int i = 0; i < 100 && obs_wr.size() < 3; i++) begin
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        rst = 1'b1;
        check("abort_wr_count", 16'(obs_wr.size()), 16'd3);
        @(negedge clk);
        rst = 1'b0;
        stray_en = 1'b1;
        clear_obs();
        repeat (6) @(negedge clk);
        #3;
        check("abort_stray_writes", 16'(obs_wr.size()), 16'd0);
        check("abort_tag_writes", 16'(obs_tag), 16'd0);
        @(negedge clk);
        stray_en = 1'b0;

        // Random fills: varied latency, gaps, held miss, occasional mid-fill reset.
        for (int n = 0; n < 40; n++) begin
            int hold;
            lat_min = 1;
            lat_max = int'($urandom_range(1, 6));
            gap     = int'($urandom_range(1, 3));
            hold    = int'($urandom_range(1, 3));
            @(negedge clk);
            stray_en      = 1'b0;
            miss_detected = 1'b1;
            miss_address  = 16'($urandom);
            for (int h = 1; h < hold; h++) begin
                @(negedge clk);
                miss_address = 16'($urandom);
            end
            @(negedge clk);
            miss_detected = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 12)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            wait_idle("random_fill");
            stray_en = 1'b1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        stray_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
